recip_div_ctrl: RTL
===================

RECIP_DIV_CTRL -- requirements
Module: recip_div_ctrl

Interface
REQ-001 SHALL have parameter W, default 32, meaning data width.
REQ-002 SHALL have parameter F, default 16, meaning fractional bits (QF).
REQ-003 SHALL have parameter TMO, default 64, meaning max cycles to wait for the reciprocal unit.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have in_valid (input, 1), in_ready (output, 1), num_in (input, W, signed QF) and den_in (input, W, signed QF): the operand request channel.
REQ-007 SHALL have rc_start (output, 1), rc_x (output, W, positive QF), rc_done (input, 1), rc_inv (input, W, QF) and rc_invalid (input, 1): the reciprocal-unit port.
REQ-008 SHALL have out_valid (output, 1), out_ready (input, 1), quot (output, W, signed QF), div_err (output, 1) and timeout (output, 1): the result channel.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, WAIT, MUL and OUT, and SHALL return to IDLE from any illegal encoding.
REQ-010 SHALL drive in_ready=1 only in IDLE.
REQ-011 SHALL, on in_valid & in_ready, register num_in, den_in sign, and |den_in| into rc_x.
REQ-012 SHALL, on acceptance with den_in==0 or den_in==-2^(W-1), skip the reciprocal unit and go directly to OUT with quot=0, div_err=1 and timeout=0.
REQ-013 SHALL, on any other acceptance, go to REQ.
REQ-014 SHALL assert rc_start for exactly one cycle while in REQ, then go to WAIT.
REQ-015 SHALL hold rc_x stable from REQ until WAIT exits.
REQ-016 SHALL, in WAIT, increment a wait counter each cycle and sample rc_inv and rc_invalid in the cycle rc_done=1.
REQ-017 SHALL ignore rc_done outside WAIT.
REQ-018 SHALL go from WAIT to MUL when rc_done=1 and rc_invalid=0.
REQ-019 SHALL go from WAIT to OUT with quot=0 and div_err=1 when rc_done=1 and rc_invalid=1.
REQ-020 SHALL go from WAIT to OUT with quot=0, div_err=1 and timeout=1 when the counter reaches TMO with no rc_done; rc_done arriving in that same cycle SHALL take priority.
REQ-021 SHALL, in MUL (one cycle), compute the 2W-bit unsigned product |num| * rc_inv, shift it right by F, and truncate.
REQ-022 SHALL apply sign = sign(num) XOR sign(den) to the MUL result.
REQ-023 SHALL saturate a positive result whose magnitude exceeds 2^(W-1)-1 to 0x7FFFFFFF (for W=32).
REQ-024 SHALL saturate a negative result whose magnitude exceeds 2^(W-1) to 0x80000000.
REQ-025 SHALL set div_err=0 and timeout=0 on a MUL result and then go to OUT.
REQ-026 SHALL, in OUT, assert out_valid and hold quot, div_err and timeout stable until out_ready=1, then go to IDLE.
REQ-027 SHALL have a total latency, for a unit returning rc_done D cycles after rc_start, of accept + 1 (REQ) + D (WAIT) + 1 (MUL), after which out_valid rises.
REQ-028 SHALL accept no new request until the out handshake completes: one operation in flight.
REQ-029 SHALL treat num_in==0 normally, giving quot=0 and div_err=0.

Reset
REQ-030 SHALL, while rst=1 at any point (including mid-WAIT), go to IDLE and force rc_start=0, out_valid=0, quot=0, div_err=0, timeout=0, rc_x=0, counter=0; in_ready SHALL read 1 once rst=0.
REQ-031 SHALL not retain any pending operation or late rc_done across reset.

Structure
REQ-032 SHALL place the FSM state enum, TWO_QF/ONE_QF constants and default W/F values in shared package fixp_pkg, also importable by the reciprocal unit.
REQ-033 SHALL be a single module with no sub-module; the saturating multiply MAY be a function in fixp_pkg.

Verification
REQ-034 SHALL verify: num=0x00030000 (3.0), den=0x00020000 (2.0), rc_inv=0x00008000 -> quot=0x00018000, div_err=0.
REQ-035 SHALL verify: num=0xFFFD0000 (-3.0), den=0x00020000, rc_inv=0x00008000 -> quot=0xFFFE8000, and rc_x=0x00020000.
REQ-036 SHALL verify: den=0 -> rc_start never asserted; out_valid 1 cycle after accept, quot=0, div_err=1, timeout=0.
REQ-037 SHALL verify: rc_done withheld -> after TMO=64 WAIT cycles timeout=1 and div_err=1; a late rc_done is ignored and the next request completes correctly.
REQ-038 SHALL verify: num=0x7FFF0000, rc_inv=0x00100000 (16.0) -> quot=0x7FFFFFFF; with den negative -> quot=0x80000000.
REQ-039 SHALL verify: rst pulsed in WAIT, then out_ready held 0 for 5 cycles on the next op -> FSM in IDLE after rst and outputs zero; quot held stable for all 5 cycles.

Source files
------------

// File: rtl/fixp_pkg.sv
// Shared fixed-point definitions for the divide controller and the reciprocal unit.
package fixp_pkg;
  localparam int DEF_W = 32;
  localparam int DEF_F = 16;

  localparam logic [DEF_W-1:0] ONE_QF = 32'h0001_0000;
  localparam logic [DEF_W-1:0] TWO_QF = 32'h0002_0000;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_MUL  = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;
endpackage

// File: rtl/recip_div_ctrl.sv
// Signed QF divide as num * recip(|den|); latency accept+1+D+1, one op in flight.
// Result is held in OUT until out_ready; in_ready only in IDLE.
module recip_div_ctrl
  import fixp_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int F   = DEF_F,
  parameter int TMO = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] num_in,
  input  logic [W-1:0] den_in,
  output logic         rc_start,
  output logic [W-1:0] rc_x,
  input  logic         rc_done,
  input  logic [W-1:0] rc_inv,
  input  logic         rc_invalid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quot,
  output logic         div_err,
  output logic         timeout
);
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [W-1:0]  ONE_LSB  = W'(1);
  localparam logic [W-1:0]  MAX_POS  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  logic [2:0]    state;
  logic [W-1:0]  num_r;
  logic [W-1:0]  inv_r;
  logic          den_neg;
  logic [CW-1:0] wait_cnt;

  logic [W-1:0]   den_mag;
  logic           den_bad;
  logic [W-1:0]   num_mag;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] mag;
  logic           res_neg;
  logic [W-1:0]   mul_res;

  assign in_ready  = (state == ST_IDLE);
  assign rc_start  = (state == ST_REQ);
  assign out_valid = (state == ST_OUT);

  always_comb begin
    den_mag = den_in[W-1] ? (~den_in + ONE_LSB) : den_in;
    den_bad = (den_in == '0) || (den_in == MIN_NEG);
  end

  // Magnitudes are treated as unsigned, so |-2^(W-1)| = 2^(W-1) stays exact.
  always_comb begin
    num_mag = num_r[W-1] ? (~num_r + ONE_LSB) : num_r;
    prod    = {{W{1'b0}}, num_mag} * {{W{1'b0}}, inv_r};
    mag     = prod >> F;
    res_neg = num_r[W-1] ^ den_neg;
    if (res_neg) begin
      if (mag > {{W{1'b0}}, MIN_NEG}) mul_res = MIN_NEG;
      else                            mul_res = ~mag[W-1:0] + ONE_LSB;
    end else begin
      if (mag > {{W{1'b0}}, MAX_POS}) mul_res = MAX_POS;
      else                            mul_res = mag[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      num_r    <= '0;
      inv_r    <= '0;
      den_neg  <= 1'b0;
      wait_cnt <= '0;
      rc_x     <= '0;
      quot     <= '0;
      div_err  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            num_r    <= num_in;
            den_neg  <= den_in[W-1];
            rc_x     <= den_mag;
            wait_cnt <= '0;
            if (den_bad) begin
              quot    <= '0;
              div_err <= 1'b1;
              timeout <= 1'b0;
              state   <= ST_OUT;
            end else begin
              state   <= ST_REQ;
            end
          end
        end
        ST_REQ: state <= ST_WAIT;
        ST_WAIT: begin
          wait_cnt <= wait_cnt + CNT_ONE;
          // A done landing on the last allowed cycle beats the timeout.
          if (rc_done) begin
            inv_r <= rc_inv;
            if (rc_invalid) begin
              quot    <= '0;
              div_err <= 1'b1;
              timeout <= 1'b0;
              state   <= ST_OUT;
            end else begin
              state   <= ST_MUL;
            end
          end else if (wait_cnt == CNT_LAST) begin
            quot    <= '0;
            div_err <= 1'b1;
            timeout <= 1'b1;
            state   <= ST_OUT;
          end
        end
        ST_MUL: begin
          quot    <= mul_res;
          div_err <= 1'b0;
          timeout <= 1'b0;
          state   <= ST_OUT;
        end
        ST_OUT: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
